// File: rtl/min_sec_count.sv
// rtl/min_sec_count.sv - minutes/seconds BCD counter with seven-segment digit outputs and hour carry
//
// Purpose:
//   Counts seconds 00-59 and minutes 00-59 from a one-cycle seconds tick.
//   Drives four seven-segment digit codes and a one-cycle carry pulse for
//   the downstream hour counter.
//
// Optional feature macro: MIN_SEC_DP_BLINK_EN
//   When defined, m0[7] (the decimal point) is the inverse of the seconds
//   ones LSB, giving a colon blink. When undefined, m0[7] is constant 0.
//
// Ports:
//   clk      in   system clock, all state updates on posedge
//   rst      in   synchronous reset, active-low
//   enb      in   seconds tick, one clk cycle per second
//   adv_min  in   one-cycle pulse, advances minutes by one with no hour carry
//   clr_sec  in   level, holds seconds at 00 while high
//   s0/s1    out  seconds ones/tens segment code {dp,g,f,e,d,c,b,a}
//   m0/m1    out  minutes ones/tens segment code {dp,g,f,e,d,c,b,a}
//   hr_enb   out  registered one-cycle carry on the 59:59 -> 00:00 rollover

module min_sec_count #(
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       adv_min,
    input  logic       clr_sec,
    output logic [7:0] s0,
    output logic [7:0] s1,
    output logic [7:0] m0,
    output logic [7:0] m1,
    output logic       hr_enb
);

    logic [3:0] sec_t, sec_o, min_t, min_o;
    logic       hr_q;

    logic       sec_at_max, min_at_max, sec_carry, hr_next;
    logic [7:0] sec_next, min_step1, min_next;
    logic [7:0] m0_code;

    // Increment a {tens,ones} BCD pair, wrapping to 00 after the terminal value.
    function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o, input int max);
        logic [7:0] r;
        if ((int'(t) * 10 + int'(o)) == max)
            r = 8'h00;
        else if (o == 4'd9)
            r = {t + 4'd1, 4'd0};
        else
            r = {t, o + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] seg(input logic [3:0] d);
        logic [7:0] r;
        case (d)
            4'd0:    r = 8'h3F;
            4'd1:    r = 8'h06;
            4'd2:    r = 8'h5B;
            4'd3:    r = 8'h4F;
            4'd4:    r = 8'h66;
            4'd5:    r = 8'h6D;
            4'd6:    r = 8'h7D;
            4'd7:    r = 8'h07;
            4'd8:    r = 8'h7F;
            4'd9:    r = 8'h6F;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        sec_at_max = (int'(sec_t) * 10 + int'(sec_o)) == SEC_MAX;
        min_at_max = (int'(min_t) * 10 + int'(min_o)) == MIN_MAX;
        // A cleared seconds field never carries into minutes.
        sec_carry  = enb && !clr_sec && sec_at_max;
        // The hour carry is judged on the tick's own minute step, before any
        // adv_min step is applied on top of it.
        hr_next    = sec_carry && min_at_max;

        if (clr_sec)
            sec_next = 8'h00;
        else if (enb)
            sec_next = bcd_inc(sec_t, sec_o, SEC_MAX);
        else
            sec_next = {sec_t, sec_o};

        min_step1 = sec_carry ? bcd_inc(min_t, min_o, MIN_MAX) : {min_t, min_o};
        min_next  = adv_min ? bcd_inc(min_step1[7:4], min_step1[3:0], MIN_MAX) : min_step1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sec_t <= 4'd0;
            sec_o <= 4'd0;
            min_t <= 4'd0;
            min_o <= 4'd0;
            hr_q  <= 1'b0;
        end else begin
            sec_t <= sec_next[7:4];
            sec_o <= sec_next[3:0];
            min_t <= min_next[7:4];
            min_o <= min_next[3:0];
            hr_q  <= hr_next;
        end
    end

    assign m0_code = seg(min_o);
    assign s0      = seg(sec_o);
    assign s1      = seg(sec_t);
    assign m1      = seg(min_t);
    assign hr_enb  = hr_q;

`ifdef MIN_SEC_DP_BLINK_EN
    assign m0 = {~sec_o[0], m0_code[6:0]};
`else
    assign m0 = m0_code;
`endif

endmodule

// File: tb/tb_min_sec_count.sv
// tb/tb_min_sec_count.sv - self-checking bench for min_sec_count

module tb_min_sec_count;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enb = 1'b0;
    logic       adv_min = 1'b0;
    logic       clr_sec = 1'b0;
    logic [7:0] s0, s1, m0, m1;
    logic       hr_enb;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: plain integer seconds/minutes.
    int  mdl_sec = 0;
    int  mdl_min = 0;
    bit  mdl_hr  = 1'b0;
    bit  armed   = 1'b0;

    logic [7:0] segtab [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

`ifdef MIN_SEC_DP_BLINK_EN
    localparam logic [7:0] M0_ZERO = 8'hBF;
`else
    localparam logic [7:0] M0_ZERO = 8'h3F;
`endif

    min_sec_count dut (
        .clk     (clk),
        .rst     (rst),
        .enb     (enb),
        .adv_min (adv_min),
        .clr_sec (clr_sec),
        .s0      (s0),
        .s1      (s1),
        .m0      (m0),
        .m1      (m1),
        .hr_enb  (hr_enb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        bit carry;
        if (!rst) begin
            mdl_sec = 0;
            mdl_min = 0;
            mdl_hr  = 1'b0;
            armed   = 1'b1;
        end else begin
            carry  = enb && !clr_sec && (mdl_sec == 59);
            mdl_hr = carry && (mdl_min == 59);
            if (clr_sec)
                mdl_sec = 0;
            else if (enb)
                mdl_sec = (mdl_sec + 1) % 60;
            if (carry)
                mdl_min = (mdl_min + 1) % 60;
            if (adv_min)
                mdl_min = (mdl_min + 1) % 60;
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_m0;
        if (armed) begin
            exp_m0 = segtab[mdl_min % 10];
`ifdef MIN_SEC_DP_BLINK_EN
            if ((mdl_sec % 2) == 0)
                exp_m0 = exp_m0 | 8'h80;
`endif
            chk("s0",     s0,     segtab[mdl_sec % 10]);
            chk("s1",     s1,     segtab[mdl_sec / 10]);
            chk("m0",     m0,     exp_m0);
            chk("m1",     m1,     segtab[mdl_min / 10]);
            chk("hr_enb", {7'd0, hr_enb}, {7'd0, mdl_hr});
        end
    end

    // One clock: inputs applied before the edge, returns 2 time units after it.
    task automatic tick(input logic e, input logic a, input logic c, input logic r);
        enb = e; adv_min = a; clr_sec = c; rst = r;
        @(posedge clk);
        #2;
        enb = 1'b0; adv_min = 1'b0; clr_sec = 1'b0; rst = 1'b1;
    endtask

    task automatic goto_time(input int mm, input int ss);
        tick(0, 0, 0, 0);
        for (int i = 0; i < mm; i++) tick(0, 1, 0, 1);
        for (int i = 0; i < ss; i++) tick(1, 0, 0, 1);
    endtask

    initial begin
        // Reset with enb held high.
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("rst_s0", s0, 8'h3F);
        chk("rst_s1", s1, 8'h3F);
        chk("rst_m0", m0, M0_ZERO);
        chk("rst_m1", m1, 8'h3F);
        chk("rst_hr", {7'd0, hr_enb}, 8'h00);
        tick(1, 0, 0, 1);
        chk("first_s0", s0, 8'h06);

        // Seconds wrap.
        tick(0, 0, 0, 0);
        for (int i = 0; i < 59; i++) tick(1, 0, 0, 1);
        chk("sw59_s1", s1, 8'h6D);
        chk("sw59_s0", s0, 8'h6F);
        tick(1, 0, 0, 1);
        chk("sw60_s1", s1, 8'h3F);
        chk("sw60_s0", s0, 8'h3F);
        chk("sw60_m0", m0 & 8'h7F, 8'h06);
        chk("sw60_hr", {7'd0, hr_enb}, 8'h00);

        // Hour carry from 59:59.
        goto_time(59, 59);
        chk("hc_m1", m1, 8'h6D);
        chk("hc_s0", s0, 8'h6F);
        chk("hc_hr0", {7'd0, hr_enb}, 8'h00);
        tick(1, 0, 0, 1);
        chk("hc_s0z", s0, 8'h3F);
        chk("hc_s1z", s1, 8'h3F);
        chk("hc_m0z", m0, M0_ZERO);
        chk("hc_m1z", m1, 8'h3F);
        chk("hc_hr1", {7'd0, hr_enb}, 8'h01);
        tick(0, 0, 0, 1);
        chk("hc_hr_after", {7'd0, hr_enb}, 8'h00);

        // adv_min wrap at 59:05.
        goto_time(59, 5);
        tick(0, 1, 0, 1);
        chk("aw_m1", m1, 8'h3F);
        chk("aw_m0", m0 & 8'h7F, 8'h3F);
        chk("aw_s0", s0, 8'h6D);
        chk("aw_s1", s1, 8'h3F);
        chk("aw_hr", {7'd0, hr_enb}, 8'h00);

        // enb carry plus adv_min at 12:59 -> 14:00.
        goto_time(12, 59);
        tick(1, 1, 0, 1);
        chk("sim_m1", m1, 8'h06);
        chk("sim_m0", m0 & 8'h7F, 8'h66);
        chk("sim_s0", s0, 8'h3F);
        chk("sim_hr", {7'd0, hr_enb}, 8'h00);

        // clr_sec at 14:59 with enb: no carry.
        for (int i = 0; i < 59; i++) tick(1, 0, 0, 1);
        tick(1, 0, 1, 1);
        chk("clr_s0", s0, 8'h3F);
        chk("clr_s1", s1, 8'h3F);
        chk("clr_m0", m0 & 8'h7F, 8'h66);
        chk("clr_m1", m1, 8'h06);

        // Reset on the same edge as the 59:59 tick.
        goto_time(59, 59);
        tick(1, 0, 0, 0);
        chk("mr_s0", s0, 8'h3F);
        chk("mr_m0", m0, M0_ZERO);
        chk("mr_hr", {7'd0, hr_enb}, 8'h00);
        tick(0, 0, 0, 1);
        chk("mr_hr_next", {7'd0, hr_enb}, 8'h00);

        // 01:01 has odd seconds, so dp is off in either build.
        tick(0, 1, 0, 1);
        tick(1, 0, 0, 1);
        chk("m0_0101", m0, 8'h06);

        // Pseudo-random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
